// File: rtl/set_circle_if.sv
// set_circle_if: host-side load/result handshake of the circle counter.
//   en        host -> engine  load strobe, honoured only while busy is low
//   central   host -> engine  {xA,yA,xB,yB,xC,yC}, 4-bit each
//   radius    host -> engine  {rA,rB,rC}, 4-bit each
//   mode      host -> engine  00 A, 01 A|B, 10 A^B, 11 A&B&C
//   busy      engine -> host  load accepted, result not yet retired
//   valid     engine -> host  one-cycle result strobe
//   candidate engine -> host  grid points in the selected set, held until the next result
interface set_circle_if;
   logic        en;
   logic [23:0] central;
   logic [11:0] radius;
   logic [1:0]  mode;
   logic        busy;
   logic        valid;
   logic [7:0]  candidate;
   modport master (output en, central, radius, mode, input busy, valid, candidate);
   modport slave  (input en, central, radius, mode, output busy, valid, candidate);
endinterface

// File: rtl/set_circle_counter.sv
// set_circle_counter: counts 8x8 grid points (1..8) inside a set combination of circles A, B, C.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  set_circle_if slave: en/central/radius/mode in, busy/valid/candidate out
module set_circle_counter (
   input  logic clk,
   input  logic rst,
   set_circle_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t      state, state_nxt;
   logic [23:0] cen;
   logic [11:0] rad;
   logic [1:0]  md;
   logic [5:0]  idx;
   logic [6:0]  cnt;
   logic [7:0]  cand;
   logic [3:0]  px, py;
   logic        in_a, in_b, in_c, hit;
   // Distances use absolute differences so off-grid centres (0, 9..15) need no sign bit;
   // 9 bits hold the worst-case sum 2*15^2 = 450.
   function automatic logic in_circle(input logic [3:0] x, y, cx, cy, r);
      logic [8:0] dx, dy, rr;
      dx = {5'd0, x >= cx ? x - cx : cx - x};
      dy = {5'd0, y >= cy ? y - cy : cy - y};
      rr = {5'd0, r};
      return dx * dx + dy * dy <= rr * rr;
   endfunction
   // idx walks x outer, y inner: idx[5:3] is x-1, idx[2:0] is y-1.
   always_comb begin
      px   = {1'b0, idx[5:3]} + 4'd1;
      py   = {1'b0, idx[2:0]} + 4'd1;
      in_a = in_circle(px, py, cen[23:20], cen[19:16], rad[11:8]);
      in_b = in_circle(px, py, cen[15:12], cen[11:8],  rad[7:4]);
      in_c = in_circle(px, py, cen[7:4],   cen[3:0],   rad[3:0]);
      hit  = md == 2'b00 ? in_a :
             md == 2'b01 ? in_a | in_b :
             md == 2'b10 ? in_a ^ in_b : in_a & in_b & in_c;
      state_nxt = state == IDLE ? (bus.en ? SCAN : IDLE) :
                  state == SCAN ? (idx == 6'd63 ? DONE : SCAN) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.en) begin
            cen <= bus.central;
            rad <= bus.radius;
            md  <= bus.mode;
            idx <= '0;
            cnt <= '0;
         end
         if (state == SCAN) begin
            idx <= idx + 6'd1;
            cnt <= cnt + {6'd0, hit};
            // publish on the last point so candidate is already final while valid is high
            if (idx == 6'd63) cand <= {1'b0, cnt + {6'd0, hit}};
         end
      end
   end
   assign bus.busy      = state != IDLE;
   assign bus.valid     = state == DONE;
   assign bus.candidate = cand;
endmodule

// File: tb/tb_set_circle_counter.sv
// tb_set_circle_counter: directed and randomized check of set_circle_counter against a grid model.
module tb_set_circle_counter;
   logic clk = 0;
   logic rst = 1;
   int   checks = 0;
   int   failures = 0;
   set_circle_if bus();
   set_circle_counter dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   function automatic bit in_c(int x, int y, int cx, int cy, int r);
      return (x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r;
   endfunction
   function automatic int ref_count(logic [23:0] c, logic [11:0] r, logic [1:0] m);
      int n = 0;
      for (int x = 1; x <= 8; x++)
         for (int y = 1; y <= 8; y++) begin
            bit a, b, cc, s;
            a  = in_c(x, y, int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
            b  = in_c(x, y, int'(c[15:12]), int'(c[11:8]),  int'(r[7:4]));
            cc = in_c(x, y, int'(c[7:4]),   int'(c[3:0]),   int'(r[3:0]));
            s  = m == 0 ? a : m == 1 ? (a | b) : m == 2 ? (a ^ b) : (a & b & cc);
            n += int'(s);
         end
      return n;
   endfunction
   // Load one job, optionally poke en mid-scan, and check latency, result and retirement.
   task automatic run(input string tag, input logic [23:0] c, input logic [11:0] r,
                      input logic [1:0] m, input int exp, input bit poke);
      int lat = 0;
      int got;
      @(negedge clk);
      bus.en = 1; bus.central = c; bus.radius = r; bus.mode = m;
      @(posedge clk); #1;
      bus.en = 0;
      while (!bus.valid && lat < 200) begin
         bus.en = poke && lat == 10;
         if (poke) begin
            bus.central = ~c; bus.radius = ~r; bus.mode = ~m;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.en = 0;
      check({tag, "_lat"}, lat, 64);
      check({tag, "_busy"}, int'(bus.busy), 1);
      got = int'(bus.candidate);
      check({tag, "_cand"}, got, exp);
      @(posedge clk); #1;
      check({tag, "_vld_off"}, int'(bus.valid), 0);
      check({tag, "_busy_off"}, int'(bus.busy), 0);
      check({tag, "_hold"}, int'(bus.candidate), got);
   endtask
   typedef struct {logic [23:0] c; logic [11:0] r; logic [1:0] m; int exp;} vec_t;
   vec_t dir[11] = '{
      '{24'h440000, 12'h200, 2'd0, 13},
      '{24'h440000, 12'h000, 2'd0, 1},
      '{24'h440000, 12'hF00, 2'd0, 64},
      '{24'h000000, 12'h100, 2'd0, 0},
      '{24'h227700, 12'h110, 2'd1, 10},
      '{24'h444400, 12'h220, 2'd1, 13},
      '{24'h444400, 12'h220, 2'd2, 0},
      '{24'h227700, 12'h110, 2'd2, 10},
      '{24'h444400, 12'h200, 2'd2, 12},
      '{24'h444444, 12'h222, 2'd3, 13},
      '{24'h114488, 12'h1F1, 2'd3, 0}
   };
   initial begin
      int seen;
      bus.en = 0; bus.central = '0; bus.radius = '0; bus.mode = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_valid", int'(bus.valid), 0);
      check("rst_cand", int'(bus.candidate), 0);
      rst = 0;
      repeat (4) @(posedge clk);
      #1;
      check("idle_busy", int'(bus.busy), 0);
      check("idle_valid", int'(bus.valid), 0);
      check("idle_cand", int'(bus.candidate), 0);
      foreach (dir[i]) run($sformatf("dir%0d", i), dir[i].c, dir[i].r, dir[i].m, dir[i].exp, 0);
      run("poke", 24'h227700, 12'h110, 2'd1, 10, 1);
      for (int i = 0; i < 64; i++) begin
         logic [23:0] c;
         logic [11:0] r;
         logic [1:0]  m;
         c = 24'($urandom);
         r = 12'($urandom);
         m = 2'($urandom);
         run($sformatf("rnd%0d", i), c, r, m, ref_count(c, r, m), 0);
      end
      @(negedge clk);
      bus.en = 1; bus.central = 24'h440000; bus.radius = 12'h200; bus.mode = 0;
      @(negedge clk);
      bus.en = 0;
      repeat (20) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("abort_busy", int'(bus.busy), 0);
      check("abort_cand", int'(bus.candidate), 0);
      seen = 0;
      repeat (70) begin
         @(negedge clk);
         seen += int'(bus.valid);
      end
      check("abort_no_valid", seen, 0);
      check("abort_idle", int'(bus.busy), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
